// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM states shared by alu_pipe and its bench
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier, one multiplier bit per cycle
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;

  // Partial-product add for the current multiplier bit; on the last bit this is the full product
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_next;

  // Operand latch on start, then shift multiplicand left / multiplier right each busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and iterative MUL
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal
);

  alu_state_t state, state_next;

  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_complete;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c;
  logic               ovf_c;
  logic               ill_c;

  assign accept       = in_valid && in_ready;
  assign is_mul       = (alu_op == ALU_MUL);
  assign mul_complete = (state == ST_MUL) && mul_busy && mul_done;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (op1),
    .b       (op2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: an accept out of OUT skips IDLE so back-to-back ops run at one per cycle
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_mul ? ST_MUL : ST_OUT;
      ST_MUL:  if (mul_complete) state_next = ST_OUT;
      ST_OUT: begin
        if (accept)         state_next = is_mul ? ST_MUL : ST_OUT;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready deliberately ignores in_valid
  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
    out_valid = (state == ST_OUT);
  end

  // Single-cycle opcode evaluation and flag generation
  always_comb begin
    sum     = {1'b0, op1} + {1'b0, op2};
    diff    = {1'b0, op1} - {1'b0, op2};
    shamt   = op2[SHAMT_W-1:0];
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_SUB: begin
        res_c   = diff[WIDTH-1:0];
        carry_c = ~diff[WIDTH];
        ovf_c   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_AND:  res_c = op1 & op2;
      ALU_OR:   res_c = op1 | op2;
      ALU_XOR:  res_c = op1 ^ op2;
      ALU_SLL:  res_c = op1 << shamt;
      ALU_SRL:  res_c = op1 >> shamt;
      ALU_SRA:  res_c = $unsigned($signed(op1) >>> shamt);
      ALU_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: res_c = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      ALU_MUL:  res_c = '0;
      default:  ill_c = 1'b1;
    endcase
  end

  // Result/flag registers: load on a non-MUL accept or when the multiplier finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      result    <= res_c;
      zero      <= (res_c == '0);
      carry_out <= carry_c;
      overflow  <= ovf_c;
      illegal   <= ill_c;
    end else if (mul_complete) begin
      result    <= mul_prod[WIDTH-1:0];
      zero      <= (mul_prod[WIDTH-1:0] == '0);
      carry_out <= 1'b0;
      overflow  <= |mul_prod[2*WIDTH-1:WIDTH];
      illegal   <= 1'b0;
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational ALU.
- Accepts one operation at a time on a valid/ready input channel and returns the result and flags on a valid/ready output channel.
- Adds an iterative unsigned multiply (MUL) opcode, an illegal-opcode error flag and full backpressure.
- Sits between the issue logic and writeback.

Parameters:
- WIDTH, 32, operand/result width; power of two, at least 8.
- SHAMT_W, $clog2(WIDTH), derived shift-amount width; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept this cycle.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  operand B.
- alu_op  in  4  opcode.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry_out  out  1  carry / no-borrow.
- overflow  out  1  signed overflow (ADD/SUB); MUL high-half nonzero.
- illegal  out  1  opcode not defined.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, result, zero, carry_out, overflow and illegal all 0; multiplier counter and accumulator 0. An in-flight MUL is discarded.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA (shift amount = op2[SHAMT_W-1:0]).
  - 1000 SLT (signed), 1001 SLTU; result is {WIDTH-1 zeros, lt}.
  - 1010 MUL: low WIDTH bits of the unsigned product.
  - 1011-1111 illegal: result=0, illegal=1, zero=1, other flags 0.
- Flags:
  - ADD: carry_out = bit WIDTH of the unsigned sum; overflow = both operands share a sign and the result sign differs.
  - SUB: carry_out = (op1 >= op2) unsigned, i.e. no borrow; overflow = operand signs differ and result sign differs from op1.
  - MUL: carry_out=0; overflow=1 if the upper WIDTH product bits are nonzero.
  - All other opcodes: carry_out=0, overflow=0.
  - zero always equals (result==0).
- FSM states: IDLE, MUL, OUT.
  - in_ready = (state==IDLE) || (state==OUT && out_ready). It is combinational and never depends on in_valid.
  - Accept = in_valid && in_ready.
  - Accept of a non-MUL opcode: result and flags are registered at that edge; state -> OUT. Latency is 1 cycle.
  - Accept of MUL: operands are latched; state -> MUL, cnt=0, 2*WIDTH accumulator cleared. One multiplier bit is processed per cycle (shift-add). When cnt reaches WIDTH-1, result/flags are registered and state -> OUT. out_valid rises exactly WIDTH cycles after the accept edge.
  - OUT: out_valid=1; result and flags stay stable until out_ready=1.
  - out_ready=1 with no accept: state -> IDLE.
  - out_ready=1 with a simultaneous accept: the new operation proceeds directly, giving back-to-back non-MUL throughput of 1 per cycle.
  - MUL state: in_ready=0; inputs are ignored; out_ready is ignored.
- Output contract: outputs only change on an accept edge, on MUL completion, or on reset. out_valid deasserts only after a handshake.
- in_valid may drop without an accept; no state change results.

Decomposition:
- Package alu_pkg: 4-bit opcode localparams (ALU_ADD … ALU_MUL) and the FSM state enum/localparams, shared with the decoder and the bench.
- Sub-module alu_mul_seq (start, operands, busy, done, 2*WIDTH product) is natural. It keeps the shift-add datapath and counter out of alu_pipe. The combinational op/flag evaluation stays in alu_pipe.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at cycle 5 of a MUL -> all outputs 0, in_ready=1 next cycle, no stale out_valid.
- WIDTH=32, out_ready=1, op1=10, op2=5, ops ADD..SLTU back-to-back -> one result per cycle: 15, 5, 0, 15, 15, 320, 0, 0, 0, 0. ADD carry_out=0; SUB carry_out=1.
- ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, carry_out=0.
- ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry_out=1.
- SUB 3-5 -> 0xFFFFFFFE, carry_out=0.
- SLT 0xFFFFFFFF vs 1 -> 1.
- SLTU 0xFFFFFFFF vs 1 -> 0.
- SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 0x10000 * 0x10000 -> out_valid exactly 32 cycles after accept, result 0, overflow=1, in_ready=0 throughout.
- MUL 7*6 -> result 42, overflow=0.
- Backpressure: out_ready=0 for 3 cycles after a result -> result/flags stable, in_ready=0. Raise out_ready with in_valid=1 -> the new op is accepted the same cycle.
- alu_op=1100 -> illegal=1, result=0, zero=1.
- WIDTH=8 variant: SLL 0x01 by op2=0x0F -> shift amount is 7, result 0x80.
